// File: rtl/store_if.sv
// Single-port data memory handshake shared by the load and store units.
// Read data returns one cycle after a read address is driven.
interface store_if;
  logic        mem_rw_mode;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_data;

  modport master (
    output mem_rw_mode,
    output mem_addr,
    output mem_write_data,
    input  mem_data
  );

  modport slave (
    input  mem_rw_mode,
    input  mem_addr,
    input  mem_write_data,
    output mem_data
  );
endinterface

// File: rtl/store.sv
// Store unit: SB/SH/SW through a memory without byte enables, using read-modify-write for sub-word stores.
// Define STORE_MISALIGN_TRAP_EN to trap misaligned SH/SW instead of forcing the low address bits.
module store (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_store_valid,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm,
  input  logic [2:0]  store_control,
  store_if.master     bus,
  output logic        stall_pc,
  output logic        ignore_curr_inst,
  output logic        store_done,
  output logic        misaligned
);

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MERGE,
    S_WRITE
`ifdef STORE_MISALIGN_TRAP_EN
    , S_FAULT
`endif
  } state_t;

  state_t      state_p0, state_nxt;
  logic [31:0] ea_p0;
  logic [31:0] wdata_p0;
  logic        half_p0;

  logic [31:0] ea_raw;
  logic [31:0] ea_acc;
  logic        legal;
  logic        accept;
`ifdef STORE_MISALIGN_TRAP_EN
  logic        misal_now;
`endif

  // Overlay the store source onto the word read back from memory.
  function automatic logic [31:0] merge_word(input logic [31:0] mem, input logic [15:0] src,
                                             input logic half, input logic [1:0] off);
    logic [31:0] w;
    w = mem;
    if (half) begin
      if (off[1]) w[31:16] = src;
      else        w[15:0]  = src;
    end else begin
      case (off)
        2'd0:    w[7:0]   = src[7:0];
        2'd1:    w[15:8]  = src[7:0];
        2'd2:    w[23:16] = src[7:0];
        default: w[31:24] = src[7:0];
      endcase
    end
    return w;
  endfunction

  always_comb begin
    ea_raw = rs1_val + imm;
    legal  = (store_control == F3_SB) || (store_control == F3_SH) || (store_control == F3_SW);
    accept = (state_p0 == S_IDLE) && i_store_valid && legal;
`ifdef STORE_MISALIGN_TRAP_EN
    misal_now = ((store_control == F3_SH) && ea_raw[0]) ||
                ((store_control == F3_SW) && (ea_raw[1:0] != 2'b00));
    ea_acc    = ea_raw;
`else
    // Without the trap, misaligned halves/words are silently pulled down to their natural alignment.
    ea_acc = ea_raw;
    if (store_control == F3_SW)      ea_acc[1:0] = 2'b00;
    else if (store_control == F3_SH) ea_acc[0]   = 1'b0;
`endif
  end

  // p0: accepted store registers; the write-data register is reused for the merged word
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_p0 <= S_IDLE;
      ea_p0    <= '0;
      wdata_p0 <= '0;
      half_p0  <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      if (accept) begin
        ea_p0    <= ea_acc;
        wdata_p0 <= rs2_val;
        half_p0  <= (store_control == F3_SH);
      end else if (state_p0 == S_MERGE) begin
        wdata_p0 <= merge_word(bus.mem_data, wdata_p0[15:0], half_p0, ea_p0[1:0]);
      end
    end
  end

  always_comb begin
    state_nxt          = state_p0;
    stall_pc           = 1'b0;
    ignore_curr_inst   = 1'b0;
    store_done         = 1'b0;
    misaligned         = 1'b0;
    bus.mem_rw_mode    = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_write_data = '0;
    case (state_p0)
      S_IDLE: begin
        stall_pc = accept;
        if (accept) begin
          state_nxt = (store_control == F3_SW) ? S_WRITE : S_READ;
`ifdef STORE_MISALIGN_TRAP_EN
          if (misal_now) state_nxt = S_FAULT;
`endif
        end
      end
      S_READ: begin
        stall_pc         = 1'b1;
        ignore_curr_inst = 1'b1;
        bus.mem_addr     = {ea_p0[31:2], 2'b00};
        state_nxt        = S_MERGE;
      end
      S_MERGE: begin
        stall_pc         = 1'b1;
        ignore_curr_inst = 1'b1;
        state_nxt        = S_WRITE;
      end
      S_WRITE: begin
        ignore_curr_inst   = 1'b1;
        store_done         = 1'b1;
        bus.mem_rw_mode    = 1'b1;
        bus.mem_addr       = {ea_p0[31:2], 2'b00};
        bus.mem_write_data = wdata_p0;
        state_nxt          = S_IDLE;
      end
`ifdef STORE_MISALIGN_TRAP_EN
      S_FAULT: begin
        ignore_curr_inst = 1'b1;
        misaligned       = 1'b1;
        state_nxt        = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
